complex_mult_hs: RTL and testbench



---
 rtl/complex_mult_hs.sv | 114 +++++++++++
 tb/tb_complex_mult_hs.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_hs.sv
// Signed complex multiplier: three real multiplies over three cycles on one
// shared multiplier, with valid/ready handshakes on both input and output.
module complex_mult_hs #(
  parameter  int W  = 8,
  localparam int OW = 2*W+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  a_re,
  input  logic signed [W-1:0]  a_im,
  input  logic signed [W-1:0]  b_re,
  input  logic signed [W-1:0]  b_im,
  input  logic                 in_conj,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] res_re,
  output logic signed [OW-1:0] res_im
);

  localparam int KW = 2*W+3;

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, DONE} state_t;

  state_t state, state_next;

  logic signed [W-1:0]  ar, ai, br;
  logic signed [W:0]    bi;
  logic signed [W:0]    b_im_ext;
  logic signed [KW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [KW-1:0] mul_x, mul_y, prod;
  logic signed [KW-1:0] k1, k2;
  logic                 accept;

  // b_im is widened by one bit so that negating the most negative value is exact.
  assign b_im_ext = {b_im[W-1], b_im};

  assign ar_x = {{(KW-W){ar[W-1]}}, ar};
  assign ai_x = {{(KW-W){ai[W-1]}}, ai};
  assign br_x = {{(KW-W){br[W-1]}}, br};
  assign bi_x = {{(KW-W-1){bi[W]}}, bi};

  assign accept = in_valid && in_ready;
  assign prod   = mul_x * mul_y;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_x      = '0;
    mul_y      = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL1;
      end
      MUL1: begin
        mul_x      = ar_x;
        mul_y      = br_x + bi_x;
        state_next = MUL2;
      end
      MUL2: begin
        mul_x      = bi_x;
        mul_y      = ar_x + ai_x;
        state_next = MUL3;
      end
      MUL3: begin
        mul_x      = br_x;
        mul_y      = ai_x - ar_x;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? MUL1 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // k3 is consumed in the same cycle it is produced, so it never needs a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ar     <= '0;
      ai     <= '0;
      br     <= '0;
      bi     <= '0;
      k1     <= '0;
      k2     <= '0;
      res_re <= '0;
      res_im <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        ar <= a_re;
        ai <= a_im;
        br <= b_re;
        bi <= in_conj ? -b_im_ext : b_im_ext;
      end
      case (state)
        MUL1: k1 <= prod;
        MUL2: k2 <= prod;
        MUL3: begin
          res_re <= OW'(k1 - k2);
          res_im <= OW'(k1 + prod);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mult_hs.sv
// Self-checking bench for complex_mult_hs: table vectors, streaming with
// back-pressure, reset mid-operation and W=4 / W=16 sweeps against a direct model.
module tb_complex_mult_hs;

  typedef struct {
    longint re;
    longint im;
  } exp_t;

  typedef struct {
    longint ar, ai, br, bi;
    bit     cj;
    longint er, ei;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W = 8 instance
  logic               in_valid, in_ready, in_conj, out_valid, out_ready;
  logic signed [7:0]  a_re, a_im, b_re, b_im;
  logic signed [16:0] res_re, res_im;

  // W = 4 instance
  logic               in_valid4, in_ready4, in_conj4, out_valid4, out_ready4;
  logic signed [3:0]  a4_re, a4_im, b4_re, b4_im;
  logic signed [8:0]  res4_re, res4_im;

  // W = 16 instance
  logic               in_valid16, in_ready16, in_conj16, out_valid16, out_ready16;
  logic signed [15:0] a16_re, a16_im, b16_re, b16_im;
  logic signed [32:0] res16_re, res16_im;

  complex_mult_hs #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .in_conj(in_conj),
    .out_valid(out_valid), .out_ready(out_ready), .res_re(res_re), .res_im(res_im)
  );

  complex_mult_hs #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a_re(a4_re), .a_im(a4_im), .b_re(b4_re), .b_im(b4_im), .in_conj(in_conj4),
    .out_valid(out_valid4), .out_ready(out_ready4), .res_re(res4_re), .res_im(res4_im)
  );

  complex_mult_hs #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a_re(a16_re), .a_im(a16_im), .b_re(b16_re), .b_im(b16_im), .in_conj(in_conj16),
    .out_valid(out_valid16), .out_ready(out_ready16), .res_re(res16_re), .res_im(res16_im)
  );

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  vec_t vecs[7];

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Direct four-multiply reference, deliberately not the three-multiply form.
  function automatic exp_t model(input longint ar, ai, br, bi, input bit cj);
    exp_t   e;
    longint bp;
    bp   = cj ? -bi : bi;
    e.re = ar*br - ai*bp;
    e.im = ar*bp + ai*br;
    return e;
  endfunction

  task automatic pop_compare(input string name, input longint act_re, input longint act_im);
    exp_t e;
    if (sb.size() == 0) begin
      check_output({name, "_unexpected_output"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_output({name, "_re"}, act_re, e.re);
      check_output({name, "_im"}, act_im, e.im);
    end
  endtask

  function automatic longint rnd(input int w);
    longint span;
    span = longint'(1) << w;
    return longint'($urandom_range(0, 32'(span - 1))) - (span >>> 1);
  endfunction

  task automatic apply_stimulus(input longint ar, ai, br, bi, input bit cj);
    a_re = 8'(ar); a_im = 8'(ai); b_re = 8'(br); b_im = 8'(bi); in_conj = cj;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    apply_stimulus(v.ar, v.ai, v.br, v.bi, v.cj);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_output($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    sb.push_back('{re: v.er, im: v.ei});
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      // Busy states must ignore whatever is offered.
      in_valid = 1'b1;
      apply_stimulus(rnd(8), rnd(8), rnd(8), rnd(8), 1'($urandom_range(0, 1)));
      lat++;
    end
    check_output($sformatf("vec%0d_latency", idx), lat, 3);
    pop_compare($sformatf("vec%0d", idx), res_re, res_im);
    @(negedge clk);
    check_output($sformatf("vec%0d_valid_clear", idx), out_valid, 0);
  endtask

  task automatic xact4(input longint ar, ai, br, bi, input bit cj);
    int n;
    @(negedge clk);
    a4_re = 4'(ar); a4_im = 4'(ai); b4_re = 4'(br); b4_im = 4'(bi); in_conj4 = cj;
    in_valid4 = 1'b1;
    #1;
    if (in_ready4) sb.push_back(model(ar, ai, br, bi, cj));
    else check_output("w4_in_ready", in_ready4, 1);
    @(negedge clk);
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (out_valid4) pop_compare("w4", res4_re, res4_im);
    else check_output("w4_timeout", out_valid4, 1);
  endtask

  task automatic xact16(input longint ar, ai, br, bi, input bit cj);
    int n;
    @(negedge clk);
    a16_re = 16'(ar); a16_im = 16'(ai); b16_re = 16'(br); b16_im = 16'(bi); in_conj16 = cj;
    in_valid16 = 1'b1;
    #1;
    if (in_ready16) sb.push_back(model(ar, ai, br, bi, cj));
    else check_output("w16_in_ready", in_ready16, 1);
    @(negedge clk);
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (out_valid16) pop_compare("w16", res16_re, res16_im);
    else check_output("w16_timeout", out_valid16, 1);
  endtask

  initial begin
    int     last_acc, sent, got, stale;
    longint c4[6];
    longint ar, ai, br, bi;
    bit     cj;

    vecs[0] = '{3, 4, 5, -2, 1'b0, 23, 14};
    vecs[1] = '{3, 4, 5, -2, 1'b1, 7, 26};
    vecs[2] = '{-128, -128, -128, -128, 1'b0, 0, 32768};
    vecs[3] = '{-128, -128, -128, 127, 1'b1, 128, 32640};
    vecs[4] = '{-128, -128, -128, -128, 1'b1, 32768, 0};
    vecs[5] = '{127, 127, 127, 127, 1'b0, 0, 32258};
    vecs[6] = '{127, -128, -128, 127, 1'b0, 0, 32513};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; apply_stimulus(0, 0, 0, 0, 0);
    in_valid4 = 1'b0; out_ready4 = 1'b1; in_conj4 = 1'b0;
    a4_re = '0; a4_im = '0; b4_re = '0; b4_im = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; in_conj16 = 1'b0;
    a16_re = '0; a16_im = '0; b16_re = '0; b16_im = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_res_re", res_re, 0);
    check_output("reset_res_im", res_im, 0);
    check_output("reset_w4_out_valid", out_valid4, 0);
    check_output("reset_w16_out_valid", out_valid16, 0);

    for (int i = 0; i < 7; i++) run_vector(vecs[i], i);

    // Continuous streaming with out_ready held high: one accept every 4 cycles.
    out_ready = 1'b1;
    last_acc  = -1;
    sent      = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      in_valid = (sent < 6);
      ar = rnd(8); ai = rnd(8); br = rnd(8); bi = rnd(8); cj = 1'($urandom_range(0, 1));
      apply_stimulus(ar, ai, br, bi, cj);
      #1;
      if (out_valid && out_ready) pop_compare("tp", res_re, res_im);
      if (in_valid && in_ready) begin
        sb.push_back(model(ar, ai, br, bi, cj));
        if (last_acc >= 0) check_output("tp_period", c - last_acc, 4);
        last_acc = c;
        sent++;
      end
    end
    in_valid = 1'b0;
    check_output("tp_accepts", sent, 6);
    check_output("tp_drained", sb.size(), 0);
    sb.delete();

    // Random back-pressure: results in order, stable and blocking input while stalled.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 600 && got < 20; c++) begin
      @(negedge clk);
      in_valid  = (sent < 20);
      out_ready = 1'($urandom_range(0, 1));
      ar = rnd(8); ai = rnd(8); br = rnd(8); bi = rnd(8); cj = 1'($urandom_range(0, 1));
      apply_stimulus(ar, ai, br, bi, cj);
      #1;
      if (out_valid && !out_ready) begin
        check_output("stall_in_ready", in_ready, 0);
        if (sb.size() > 0) begin
          check_output("stall_hold_re", res_re, sb[0].re);
          check_output("stall_hold_im", res_im, sb[0].im);
        end
      end
      if (out_valid && out_ready) begin
        pop_compare($sformatf("stream%0d", got), res_re, res_im);
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(ar, ai, br, bi, cj));
        sent++;
      end
    end
    in_valid = 1'b0;
    check_output("stream_received", got, 20);
    check_output("stream_queue_empty", sb.size(), 0);
    sb.delete();

    // Reset while in MUL2 discards the transaction.
    @(negedge clk);
    out_ready = 1'b0;
    apply_stimulus(100, -3, -50, 7, 0);
    in_valid = 1'b1;
    #1;
    check_output("rstA_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rstA_out_valid", out_valid, 0);
    check_output("rstA_res_re", res_re, 0);
    check_output("rstA_res_im", res_im, 0);
    check_output("rstA_in_ready", in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    check_output("rstA_no_stale", stale, 0);

    // Reset while holding a pending result in DONE.
    @(negedge clk);
    apply_stimulus(9, -5, -7, 3, 0);
    in_valid = 1'b1;
    #1;
    check_output("rstB_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 8 && !out_valid; n++) @(negedge clk);
    check_output("rstB_valid_before", out_valid, 1);
    @(negedge clk);
    check_output("rstB_backpressure_valid", out_valid, 1);
    check_output("rstB_backpressure_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rstB_out_valid", out_valid, 0);
    check_output("rstB_res_re", res_re, 0);
    check_output("rstB_res_im", res_im, 0);
    check_output("rstB_in_ready", in_ready, 1);
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    check_output("rstB_no_stale", stale, 0);

    // W = 4 sweep over the corner set, both conjugate settings.
    c4[0] = -8; c4[1] = -7; c4[2] = -1; c4[3] = 0; c4[4] = 1; c4[5] = 7;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int k = 0; k < 6; k++)
          for (int l = 0; l < 6; l++)
            for (int m = 0; m < 2; m++)
              xact4(c4[i], c4[j], c4[k], c4[l], 1'(m));
    check_output("w4_queue_empty", sb.size(), 0);
    sb.delete();

    // W = 16 random, with the extremes mixed in.
    xact16(-32768, -32768, -32768, -32768, 0);
    xact16(-32768, -32768, -32768, -32768, 1);
    xact16(32767, -32768, -32768, 32767, 1);
    for (int i = 0; i < 150; i++) begin
      ar = ($urandom_range(0, 4) == 0) ? -32768 : rnd(16);
      ai = rnd(16);
      br = rnd(16);
      bi = ($urandom_range(0, 4) == 0) ? -32768 : rnd(16);
      xact16(ar, ai, br, bi, 1'($urandom_range(0, 1)));
    end
    check_output("w16_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
